// File: rtl/fare_lookup_ctrl_if.sv
// fare_lookup_ctrl_if
// Bundles the two lookup clients, the lookup result and the port A read
// interface of the fare/display RAM.
//   c0_* / c1_*      : request level, start/end line and station, done pulse
//   price, price_err : result of the last completed lookup
//   busy             : controller not idle
//   ram_en, ram_addr : port A read request (read-only port)
//   ram_dout         : port A read data
// slave  : the lookup controller side
// master : the side that plays the clients and the RAM
interface fare_lookup_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              c0_req;
  logic [1:0]        c0_sline;
  logic [6:0]        c0_spoint;
  logic [1:0]        c0_eline;
  logic [6:0]        c0_epoint;
  logic              c1_req;
  logic [1:0]        c1_sline;
  logic [6:0]        c1_spoint;
  logic [1:0]        c1_eline;
  logic [6:0]        c1_epoint;
  logic              c0_done;
  logic              c1_done;
  logic [11:0]       price;
  logic              price_err;
  logic              busy;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [11:0]       ram_dout;

  modport slave (
    input  c0_req, c0_sline, c0_spoint, c0_eline, c0_epoint,
    input  c1_req, c1_sline, c1_spoint, c1_eline, c1_epoint,
    input  ram_dout,
    output c0_done, c1_done, price, price_err, busy, ram_en, ram_addr
  );

  modport master (
    output c0_req, c0_sline, c0_spoint, c0_eline, c0_epoint,
    output c1_req, c1_sline, c1_spoint, c1_eline, c1_epoint,
    output ram_dout,
    input  c0_done, c1_done, price, price_err, busy, ram_en, ram_addr
  );
endinterface

// File: rtl/fare_lookup_ctrl.sv
// fare_lookup_ctrl
// Round-robin arbiter and sequencer for fare lookups through port A of the
// shared fare/display RAM. The 100x100 fare matrix sits at 0..9999; the
// display image above it is never touched from here.
// Ports:
//   clk   : system (display domain) clock
//   rst_n : asynchronous active-low reset
//   bus   : fare_lookup_ctrl_if.slave (clients, result, RAM port A)
//
// state | meaning
// IDLE  | arbitrate between the two requesters, latch winner's operands
// CALC  | validate stations, register the matrix address
// READ  | one-cycle read strobe on port A
// WAIT  | count out the RAM read latency, capture the fare
// DONE  | one-cycle done pulse to the granted client
module fare_lookup_ctrl #(
  parameter int LEN0       = 27,
  parameter int LEN1       = 26,
  parameter int LEN2       = 29,
  parameter int LEN3       = 18,
  parameter int ROW_STRIDE = 100,
  parameter int RD_LAT     = 2,
  parameter int ADDR_W     = 19
) (
  input logic               clk,
  input logic               rst_n,
  fare_lookup_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CALC, READ, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic              last_grant;
  logic              gnt_id;
  logic [1:0]        sline, eline;
  logic [6:0]        spoint, epoint;
  logic [2:0]        wait_cnt;
  logic [11:0]       price_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;

  logic              grant_any;
  logic              grant_sel;
  logic [7:0]        row, col;
  logic              lookup_valid;
  logic [ADDR_W-1:0] addr_calc;

  function automatic logic [7:0] line_base(input logic [1:0] line);
    case (line)
      2'd0:    line_base = 8'd0;
      2'd1:    line_base = 8'(LEN0);
      2'd2:    line_base = 8'(LEN0 + LEN1);
      default: line_base = 8'(LEN0 + LEN1 + LEN2);
    endcase
  endfunction

  function automatic logic [7:0] line_len(input logic [1:0] line);
    case (line)
      2'd0:    line_len = 8'(LEN0);
      2'd1:    line_len = 8'(LEN1);
      2'd2:    line_len = 8'(LEN2);
      default: line_len = 8'(LEN3);
    endcase
  endfunction

  // Ties go to the client that did not win last time.
  always_comb begin
    grant_any = bus.c0_req | bus.c1_req;
    if (bus.c0_req && bus.c1_req) grant_sel = ~last_grant;
    else                          grant_sel = bus.c1_req;
  end

  // Row/column fit in 8 bits even for out-of-range station indices
  // (largest base + 127 < 256), so the validity test sees true values.
  always_comb begin
    row          = line_base(sline) + {1'b0, spoint};
    col          = line_base(eline) + {1'b0, epoint};
    lookup_valid = ({1'b0, spoint} < line_len(sline)) &&
                   ({1'b0, epoint} < line_len(eline));
    addr_calc    = ADDR_W'(row) * ADDR_W'(ROW_STRIDE) + ADDR_W'(col);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.c0_done = 1'b0;
    bus.c1_done = 1'b0;
    bus.busy    = 1'b1;
    bus.ram_en  = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (grant_any) state_nxt = CALC;
      end
      CALC: state_nxt = lookup_valid ? READ : DONE;
      READ: begin
        bus.ram_en = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: if (wait_cnt == 3'd0) state_nxt = DONE;
      DONE: begin
        bus.c0_done = ~gnt_id;
        bus.c1_done = gnt_id;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      sline      <= '0;
      spoint     <= '0;
      eline      <= '0;
      epoint     <= '0;
      wait_cnt   <= '0;
      price_q    <= '0;
      err_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          gnt_id     <= grant_sel;
          last_grant <= grant_sel;
          sline      <= grant_sel ? bus.c1_sline  : bus.c0_sline;
          spoint     <= grant_sel ? bus.c1_spoint : bus.c0_spoint;
          eline      <= grant_sel ? bus.c1_eline  : bus.c0_eline;
          epoint     <= grant_sel ? bus.c1_epoint : bus.c0_epoint;
        end
        CALC: begin
          if (lookup_valid) begin
            addr_q <= addr_calc;
          end else begin
            price_q <= 12'd0;
            err_q   <= 1'b1;
          end
        end
        // Down-counter reaches zero in the cycle ram_dout becomes valid.
        READ: wait_cnt <= 3'(RD_LAT - 1);
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            price_q <= bus.ram_dout;
            err_q   <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.price     = price_q;
  assign bus.price_err = err_q;
  assign bus.ram_addr  = addr_q;

endmodule
